// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM for the 8x16 register file / ALU datapath.
// Latches an instruction on s (only while idle in WAIT) and steps the datapath
// strobes one state per cycle; all outputs are Moore decodes of state and IR.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   s, in          start strobe and instruction word
//   w, illegal     idle/ready flag, 1-cycle undecodable-opcode pulse
//   readnum        register read select
//   writenum       register write select
//   write          register write enable
//   loada..loads   A/B/C/status register load enables
//   asel, bsel     ALU operand muxes
//   vsel           write-back source (1 = datapath_in, 0 = C)
//   shift, aluop   shifter and ALU op
//   sximm8         sign-extended IR[7:0]
module instr_sequencer #(
   parameter int WIDTH = 16,
   parameter int RSEL  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s,
   input  logic [WIDTH-1:0] in,
   output logic             w,
   output logic             illegal,
   output logic [RSEL-1:0]  readnum,
   output logic [RSEL-1:0]  writenum,
   output logic             write,
   output logic             loada,
   output logic             loadb,
   output logic             loadc,
   output logic             loads,
   output logic             asel,
   output logic             bsel,
   output logic             vsel,
   output logic [1:0]       shift,
   output logic [1:0]       aluop,
   output logic [WIDTH-1:0] sximm8
);

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WIMM,
      S_GETA,
      S_GETB,
      S_ALU,
      S_WREG
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ir_q, ir_d;

   logic [2:0]      opcode;
   logic [1:0]      op;
   logic [RSEL-1:0] rn, rd, rm;
   logic            is_movi, is_movr, is_alu, is_cmp, is_mvn;
   logic            unary;

   assign opcode = ir_q[15:13];
   assign op     = ir_q[12:11];
   assign rn     = ir_q[8 +: RSEL];
   assign rd     = ir_q[5 +: RSEL];
   assign rm     = ir_q[0 +: RSEL];

   assign is_movi = (opcode == 3'b110) && (op == 2'b10);
   assign is_movr = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu  = (opcode == 3'b101);
   assign is_cmp  = is_alu && (op == 2'b01);
   assign is_mvn  = is_alu && (op == 2'b11);
   // single-operand forms skip GETA and zero the ALU A input
   assign unary   = is_movr || is_mvn;

   assign shift  = ir_q[4:3];
   assign aluop  = (opcode == 3'b110) ? 2'b00 : op;
   assign sximm8 = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};

   // IR only captures in WAIT, so it is stable for the whole instruction
   assign ir_d = (state_q == S_WAIT && s) ? in : ir_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_WAIT;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_WAIT:   state_d = s ? S_DECODE : S_WAIT;
         S_DECODE: begin
            if (is_movi)      state_d = S_WIMM;
            else if (unary)   state_d = S_GETB;
            else if (is_alu)  state_d = S_GETA;
            else              state_d = S_WAIT;
         end
         S_WIMM:   state_d = S_WAIT;
         S_GETA:   state_d = S_GETB;
         S_GETB:   state_d = S_ALU;
         S_ALU:    state_d = is_cmp ? S_WAIT : S_WREG;
         S_WREG:   state_d = S_WAIT;
         default:  state_d = S_WAIT;
      endcase
   end

   always_comb begin
      w        = 1'b0;
      illegal  = 1'b0;
      readnum  = '0;
      writenum = '0;
      write    = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      vsel     = 1'b0;
      unique case (state_q)
         S_WAIT:   w = 1'b1;
         S_DECODE: illegal = !(is_movi || is_movr || is_alu);
         S_WIMM: begin
            writenum = rn;
            vsel     = 1'b1;
            write    = 1'b1;
         end
         S_GETA: begin
            readnum = rn;
            loada   = 1'b1;
         end
         S_GETB: begin
            readnum = rm;
            loadb   = 1'b1;
         end
         S_ALU: begin
            asel  = unary;
            loads = is_cmp;
            loadc = !is_cmp;
         end
         S_WREG: begin
            writenum = rd;
            write    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
